// File: rtl/mem_test_initiator.sv
// Built-in self-test initiator: writes a pattern over an address window, reads it back and checks it.
// Optional request timeout is compiled in with MEMTEST_TIMEOUT_EN.
module mem_test_initiator #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic                  ready,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);

  // state | meaning
  // IDLE  | waiting for start; arm_q marks the launch cycle after start
  // WR    | issuing writes (modes 0-2) or the write half of a location (mode 3)
  // GAP   | one idle cycle between the write and read passes
  // RD    | issuing reads and comparing rdata against the expected pattern
  // DONE  | one-cycle completion pulse, status is final
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RD, S_DONE} state_t;

  state_t                state_q, state_n;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         cnt_q, idx_q, idx_n, cnt_in;
  logic                  arm_q;
  logic                  launch, xfer, last, mismatch, to_hit;
  logic                  valid_n, wr_rd_n, busy_n, done_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [WIDTH-1:0]      wdata_n;
  logic [CW-1:0]         err_n;

  function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m, input logic [ADDR_WIDTH-1:0] a);
    logic [WIDTH-1:0] p;
    p = WIDTH'(a);
    if (m == 2'd1) p = ~p;
    else if (m == 2'd2)
      for (int i = 0; i < WIDTH; i++) p[i] = ((i % 2) == 0) ^ a[0];
    return p;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] b, input logic [CW-1:0] k);
    logic [CW:0] sum;
    sum = (CW+1)'(b) + (CW+1)'(k);
    if (sum >= (CW+1)'(DEPTH)) sum = sum - (CW+1)'(DEPTH);
    return sum[ADDR_WIDTH-1:0];
  endfunction

  assign cnt_in   = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
  assign launch   = (state_q == S_IDLE) && !arm_q && start;
  assign xfer     = valid && ready;
  assign last     = (idx_q == cnt_q - 1'b1);
  assign mismatch = xfer && (state_q == S_RD) && (rdata != pattern(mode_q, addr));
  assign err_n    = err_count + CW'(mismatch);

`ifdef MEMTEST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q;

  // Down-counter of stalled cycles; reloads whenever the request is not stalled.
  always_ff @(posedge clk or negedge res) begin
    if (!res)                wait_q <= TW'(TIMEOUT - 1);
    else if (valid && !ready) begin
      if (wait_q != '0)      wait_q <= wait_q - 1'b1;
    end else                 wait_q <= TW'(TIMEOUT - 1);
  end

  assign to_hit = valid && !ready && (wait_q == '0);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) state_q <= S_IDLE;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: begin
        if (arm_q)                         state_n = S_WR;
        else if (launch && cnt_in == '0)   state_n = S_DONE;
      end
      S_WR: begin
        if (to_hit)                        state_n = S_DONE;
        else if (xfer) begin
          if (mode_q == 2'd3)              state_n = S_RD;
          else if (last)                   state_n = S_GAP;
        end
      end
      S_GAP:                               state_n = S_RD;
      S_RD: begin
        if (to_hit)                        state_n = S_DONE;
        else if (xfer) begin
          if (last)                        state_n = S_DONE;
          else if (mode_q == 2'd3)         state_n = S_WR;
        end
      end
      S_DONE:                              state_n = S_IDLE;
      default:                             state_n = S_IDLE;
    endcase
  end

  // Next request is computed from the next state so it appears on the completing edge.
  always_comb begin
    idx_n = idx_q;
    if (state_q == S_IDLE) idx_n = '0;
    else if (xfer) begin
      if (state_q == S_WR && mode_q == 2'd3) idx_n = idx_q;
      else if (state_q == S_WR && last)      idx_n = '0;
      else                                   idx_n = idx_q + 1'b1;
    end
    valid_n = 1'b0;
    wr_rd_n = 1'b0;
    addr_n  = '0;
    wdata_n = '0;
    case (state_n)
      S_WR: begin
        valid_n = 1'b1;
        wr_rd_n = 1'b1;
        addr_n  = wrap_addr(base_q, idx_n);
        wdata_n = pattern(mode_q, addr_n);
      end
      S_RD: begin
        valid_n = 1'b1;
        addr_n  = wrap_addr(base_q, idx_n);
      end
      default: ;
    endcase
    busy_n = (state_n == S_WR) || (state_n == S_GAP) || (state_n == S_RD);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      valid <= 1'b0;
      wr_rd <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx_q <= '0;
    end else begin
      valid <= valid_n;
      wr_rd <= wr_rd_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      busy  <= busy_n;
      done  <= done_n;
      idx_q <= idx_n;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mode_q         <= '0;
      base_q         <= '0;
      cnt_q          <= '0;
      arm_q          <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
    end else if (launch) begin
      mode_q         <= mode;
      base_q         <= start_addr;
      cnt_q          <= cnt_in;
      arm_q          <= (cnt_in != '0);
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= (cnt_in == '0);
      timeout        <= 1'b0;
    end else begin
      arm_q <= 1'b0;
      if (mismatch) begin
        err_count <= err_n;
        if (err_count == '0) first_err_addr <= addr;
      end
      if (to_hit) timeout <= 1'b1;
      if (state_q != S_DONE && state_n == S_DONE)
        pass <= (err_n == '0) && !to_hit;
    end
  end

endmodule

// File: tb/tb_mem_test_initiator.sv
// Directed bench for mem_test_initiator with a behavioural memory (latency, stuck-ready, bit-flip fault).
// Timeout scenario is exercised only when MEMTEST_TIMEOUT_EN is defined.
module tb_mem_test_initiator;
  localparam int W  = 8;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count = '0;
  logic          valid, wr_rd, busy, done, pass, timeout;
  logic [AW-1:0] addr, first_err_addr;
  logic [W-1:0]  wdata, rdata;
  logic [AW:0]   err_count;
  logic          ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] mem [D];
  int  lat   = 0;
  bit  stuck = 0;
  bit  flip7 = 0;
  int  wc    = 0;

  int            nlog = 0;
  logic          log_wr    [256];
  logic [AW-1:0] log_addr  [256];
  logic [W-1:0]  log_wdata [256];

  int            unstable = 0;
  bit            hold_prev = 0;
  logic          pv_wr;
  logic [AW-1:0] pv_addr;
  logic [W-1:0]  pv_wdata;

  mem_test_initiator dut (
    .clk(clk), .res(res), .start(start), .mode(mode), .start_addr(start_addr), .count(count),
    .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign rdata = (valid && !wr_rd) ? (mem[addr] ^ ((flip7 && addr == 5'd7) ? 8'h01 : 8'h00)) : 8'h00;

  always @(posedge clk) begin
    if (valid && ready) begin
      if (wr_rd) mem[addr] <= wdata;
      if (nlog < 256) begin
        log_wr[nlog]    = wr_rd;
        log_addr[nlog]  = addr;
        log_wdata[nlog] = wdata;
      end
      nlog++;
    end
  end

  // Memory ready model plus a check that a stalled request does not change.
  always @(negedge clk) begin
    if (hold_prev && (!valid || wr_rd !== pv_wr || addr !== pv_addr || wdata !== pv_wdata))
      unstable++;
    if (stuck)              ready = 1'b0;
    else if (lat == 0)      ready = 1'b1;
    else if (!valid) begin  ready = 1'b0; wc = 0; end
    else if (wc >= lat) begin ready = 1'b1; wc = 0; end
    else begin              ready = 1'b0; wc++; end
    hold_prev = valid && !ready;
    pv_wr     = wr_rd;
    pv_addr   = addr;
    pv_wdata  = wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] m, input int sa, input int cnt, output int base);
    @(negedge clk);
    mode       = m;
    start_addr = AW'(sa);
    count      = (AW+1)'(cnt);
    start      = 1'b1;
    base       = nlog;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic wait_done(input int budget);
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int base, bad, k;
    logic [W-1:0] exp_d;

    // reset values
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_wr_rd", wr_rd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    res = 1'b1;

    // mode 0, single location at 15
    launch(2'd0, 15, 1, base);
    chk("t1_busy_c1", busy, 0);
    chk("t1_valid_c1", valid, 0);
    @(negedge clk); cyc++;
    chk("t1_busy_c2", busy, 1);
    chk("t1_valid_c2", valid, 1);
    chk("t1_wr_c2", wr_rd, 1);
    chk("t1_addr_c2", addr, 15);
    chk("t1_wdata_c2", wdata, 8'h0F);
    wait_done(50);
    chk("t1_cycles", cyc, 5);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_nxfer", nlog - base, 2);
    chk("t1_log0", {log_wr[base], log_addr[base], log_wdata[base]}, {1'b1, 5'd15, 8'h0F});
    chk("t1_log1", {log_wr[base+1], log_addr[base+1]}, {1'b0, 5'd15});
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_valid_idle", valid, 0);
    chk("t1_addr_idle", addr, 0);
    chk("t1_pass_held", pass, 1);

    // mode 2 with wrap and 2-cycle ready latency
    lat = 2;
    launch(2'd2, 28, 8, base);
    wait_done(200);
    chk("t2_pass", pass, 1);
    chk("t2_err", err_count, 0);
    chk("t2_nxfer", nlog - base, 16);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      k = (28 + i) % 32;
      exp_d = (k % 2 == 0) ? 8'h55 : 8'hAA;
      if (log_wr[base+i] !== 1'b1 || log_addr[base+i] !== AW'(k) || log_wdata[base+i] !== exp_d) bad++;
      if (log_wr[base+8+i] !== 1'b0 || log_addr[base+8+i] !== AW'(k)) bad++;
    end
    chk("t2_sequence", bad, 0);
    chk("t2_stable", unstable, 0);
    lat = 0;

    // full depth mode 1, memory flips bit 0 at address 7
    flip7 = 1;
    launch(2'd1, 0, 32, base);
    wait_done(200);
    chk("t3_err", err_count, 1);
    chk("t3_first", first_err_addr, 7);
    chk("t3_pass", pass, 0);
    chk("t3_cycles", cyc, 67);
    flip7 = 0;

    // count 0 completes immediately with pass
    launch(2'd0, 3, 0, base);
    chk("t6_cycles", cyc, 1);
    chk("t6_done", done, 1);
    chk("t6_pass", pass, 1);
    chk("t6_busy", busy, 0);
    chk("t6_err_clr", err_count, 0);
    chk("t6_nxfer", nlog - base, 0);

    // mode 3 interleaved, full depth
    launch(2'd3, 0, 32, base);
    wait_done(200);
    chk("t4_cycles", cyc, 66);
    chk("t4_pass", pass, 1);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (log_wr[base+2*i] !== 1'b1 || log_addr[base+2*i] !== AW'(i) || log_wdata[base+2*i] !== W'(i)) bad++;
      if (log_wr[base+2*i+1] !== 1'b0 || log_addr[base+2*i+1] !== AW'(i)) bad++;
    end
    chk("t4_order", bad, 0);

    // reset during the read pass, then rerun cleanly
    flip7 = 1;
    launch(2'd0, 5, 8, base);
    k = 0;
    while (!(valid === 1'b1 && wr_rd === 1'b0 && addr === 5'd8) && k < 100) begin
      @(negedge clk); k++;
    end
    chk("t5_reached_rd", k < 100, 1);
    chk("t5_err_before", err_count, 1);
    res = 1'b0;
    #1;
    chk("t5_valid", valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err_count, 0);
    chk("t5_first", first_err_addr, 0);
    chk("t5_done", done, 0);
    @(negedge clk);
    res   = 1'b1;
    flip7 = 0;
    launch(2'd0, 5, 8, base);
    wait_done(100);
    chk("t5_rerun_cycles", cyc, 19);
    chk("t5_rerun_pass", pass, 1);

    // count above DEPTH is clamped
    launch(2'd0, 0, 40, base);
    wait_done(200);
    chk("t7_cycles", cyc, 67);
    chk("t7_nxfer", nlog - base, 64);
    chk("t7_pass", pass, 1);

`ifdef MEMTEST_TIMEOUT_EN
    stuck = 1;
    launch(2'd0, 0, 4, base);
    wait_done(200);
    chk("t8_cycles", cyc, 66);
    chk("t8_timeout", timeout, 1);
    chk("t8_valid", valid, 0);
    chk("t8_pass", pass, 0);
    stuck = 0;
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_test_initiator.md
# mem_test_initiator

Hardware initiator for the valid/ready single-port memory interface (clk, wr_rd, addr, wdata, rdata, valid, ready). On a start pulse it writes a deterministic pattern over an address window, reads the window back, compares each word, and reports pass/fail, error count and first failing address. It sits in front of the memory as a built-in self-test engine, replacing software-driven write/read sequences.

## Interface
- WIDTH, 8, data width
- DEPTH, 32, memory locations
- ADDR_WIDTH, $clog2(DEPTH), address width
- TIMEOUT, 64, max cycles a request waits for ready (used only with MEMTEST_TIMEOUT_EN)

- clk  in  1  clock, all logic on rising edge
- res  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start pulse; ignored while busy
- mode  in  2  0 address-as-data, 1 inverted address, 2 checkerboard, 3 interleaved write/read
- start_addr  in  ADDR_WIDTH  first location
- count  in  ADDR_WIDTH+1  number of locations
- valid  out  1  request valid
- wr_rd  out  1  1 write, 0 read
- addr  out  ADDR_WIDTH  request address
- wdata  out  WIDTH  write data
- ready  in  1  memory completes request
- rdata  in  WIDTH  read data, valid when valid&ready&~wr_rd
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  last test had zero errors and no timeout; held until next start
- err_count  out  ADDR_WIDTH+1  mismatches in last test
- first_err_addr  out  ADDR_WIDTH  address of first mismatch
- timeout  out  1  last test aborted on ready timeout

## Operation
- States: IDLE, WR, GAP, RD, DONE.
- IDLE + start: latch mode, start_addr, and count clamped to DEPTH; clear err_count, first_err_addr, pass, timeout; go WR. count=0 goes directly to DONE with pass=1 and no transfers.
- Location k (0..count-1): address (start_addr+k) mod DEPTH. The address wraps from DEPTH-1 to 0.
- Expected data for address a: mode 0 = a zero-extended or truncated to WIDTH; mode 1 = bitwise inverse of mode 0; mode 2 = 0x55.. pattern if a[0]=0, else 0xAA.. pattern (WIDTH bits).
- Modes 0-2: WR issues count writes, then one cycle in GAP with valid=0, then RD issues count reads.
- Mode 3: per location, one write then one read of the same address, then the next location. No GAP.
- Each read transfer compares rdata to the expected data. On mismatch, err_count increments. The first mismatch latches first_err_addr.
- After the last transfer: DONE for one cycle (done=1, busy=0 next), pass=(err_count==0)&~timeout after that transfer's compare, then IDLE.
- Outputs hold after DONE. Transfer outputs return to valid=0, wr_rd=0, addr=0, wdata=0.

## Timing
- All outputs registered. Reset values: valid 0, wr_rd 0, addr 0, wdata 0, busy 0, done 0, pass 0, err_count 0, first_err_addr 0, timeout 0.
- busy and first valid rise at the first edge after the edge sampling start (1-cycle latency).
- Handshake: valid, wr_rd, addr and wdata stay stable while valid=1 and ready=0. A transfer completes on an edge with valid&ready.
- Back-to-back transfers: the next request is presented on the same edge that completes the previous one, with zero bubbles, except in GAP.
- A read completes and is compared on the same edge. rdata is sampled only on that edge.
- Test duration with ready tied high: modes 0-2 = 2*count+3 cycles from start to done; mode 3 = 2*count+2 cycles.
- When res is asserted mid-test, all outputs go to reset values immediately, with no completion pulse.

## Configuration
- MEMTEST_TIMEOUT_EN defined: a per-request counter counts cycles with valid=1 and ready=0. When it reaches TIMEOUT, the engine sets timeout=1, drops valid, and goes to DONE with pass=0. The counter clears on every completed transfer.
- Undefined: no counter is present, timeout is tied to 0, and the engine waits for ready indefinitely.

## Test plan
- Mode 0, start_addr 15, count 1, ready tied high: one write then one read at addr 15 with wdata 0x0F; done at cycle 5; pass=1; err_count=0.
- Mode 2, start_addr 28, count 8, memory ready with 2-cycle latency: addresses run 28..31,0..3 (wrap); requests stay stable while ready=0; pass=1.
- Full depth, mode 1, memory model flips bit 0 at addr 7: err_count=1, first_err_addr=7, pass=0.
- Mode 3, count 32: order is W0,R0,W1,R1,...; done at cycle 66 with ready tied high; pass=1.
- res low during the RD phase, then start again: valid=0 immediately and all status is cleared; the second run completes with pass=1. Also check count=0 gives done at next cycle with pass=1, and count=40 is clamped to 32.
- With MEMTEST_TIMEOUT_EN, ready stuck low: timeout=1 and valid=0 after 64 waiting cycles, then done, pass=0.
